// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory loader and the
// instruction memory itself (state encoding, word geometry, byte-lane order).
package imem_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;

    // Big-endian lane order: lane 0 (first byte of a word) occupies
    // [WORD_W-1:LANE0_LSB], i.e. [31:24]; later lanes sit below it.
    localparam int unsigned LANE0_LSB  = WORD_W - BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

endpackage

// File: rtl/imem_pack_be.sv
// imem_pack_be: 4-byte big-endian pack register.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clr           restart packing at lane 0 (new load)
//   push          accept data into the next lane
//   data          incoming byte
//   word_c        completed word if this push fills lane 3 (combinational)
//   full_c        this push completes a word (combinational)
module imem_pack_be
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word_c,
    output logic              full_c
);

    localparam int unsigned IDX_W = $clog2(WORD_BYTES);

    // Lanes 0..2 are held here; lane 3 is the byte arriving with the last push.
    logic [LANE0_LSB-1:0] hold_q;
    logic [IDX_W-1:0]     idx_q;

    // Shift register and lane index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            idx_q  <= '0;
        end else if (clr) begin
            hold_q <= '0;
            idx_q  <= '0;
        end else if (push) begin
            hold_q <= LANE0_LSB'({hold_q, data});
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign word_c = {hold_q, data};
    assign full_c = push && (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the instruction memory.
// Packs bytes big-endian into 32-bit words, writes one word per mem_we
// pulse, stalls the CPU while loading and checks a trailing XOR checksum.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 begin a load (only honoured when idle)
//   base_addr, num_words  load address (word-aligned internally) and length
//   s_valid/s_ready/s_data  byte stream handshake
//   mem_we/mem_addr/mem_wdata  instruction memory write port
//   cpu_hold, busy        asserted for the duration of a load
//   done                  one-cycle completion pulse
//   err                   checksum mismatch, sticky until next start
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              s_valid,
    input  logic [BYTE_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BYTE_W-1:0]   csum_q;

    logic                hs_c;
    logic                push_c;
    logic                clr_c;
    logic                full_c;
    logic [WORD_W-1:0]   word_c;

    assign hs_c   = s_valid && s_ready;
    assign push_c = hs_c && (state == ST_RECV);
    // busy is still high in the done cycle, so a start there is ignored too
    assign clr_c  = (state == ST_IDLE) && start && !busy;

    imem_pack_be u_pack (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr_c),
        .push   (push_c),
        .data   (s_data),
        .word_c (word_c),
        .full_c (full_c)
    );

    // Load sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                    if (clr_c) begin
                        addr_q   <= base_addr & ~ADDR_W'(3);
                        cnt_q    <= num_words;
                        csum_q   <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        s_ready  <= 1'b1;
                        state    <= (num_words == '0) ? ST_CHECK : ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (push_c) begin
                        csum_q <= csum_q ^ s_data;
                        if (full_c) begin
                            state     <= ST_WRITE;
                            s_ready   <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_q;
                            mem_wdata <= word_c;
                        end
                    end
                end
                ST_WRITE: begin
                    // Address wraps silently at the top of memory
                    addr_q  <= addr_q + ADDR_W'(WORD_BYTES);
                    cnt_q   <= cnt_q - CNT_W'(1);
                    s_ready <= 1'b1;
                    state   <= (cnt_q == CNT_W'(1)) ? ST_CHECK : ST_RECV;
                end
                ST_CHECK: begin
                    if (hs_c) begin
                        err     <= (s_data != csum_q);
                        done    <= 1'b1;
                        s_ready <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed loads checked against a
// word-list / XOR reference model of the loader.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [6:0]  num_words;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ld_words[16];
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    bit          chk_idle = 0;

    imem_loader #(.ADDR_W(8), .CNT_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write-port and done-pulse monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_idle) begin
                check("done_pulse", 32'(done), 32'd0);
                check("idle_busy", 32'({busy, cpu_hold}), 32'd0);
                chk_idle = 0;
            end
            if (mem_we) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
                check("we_s_ready", 32'(s_ready), 32'd0);
            end
            if (done) begin
                check("done_busy", 32'({busy, cpu_hold}), 32'd3);
                chk_idle = 1;
            end
        end else begin
            chk_idle = 0;
        end
    end

    function automatic logic [7:0] model_csum(input int n);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 4; j++)
                c ^= 8'(ld_words[i] >> (8 * (3 - j)));
        return c;
    endfunction

    // Offer one byte; returns at the negedge before the edge that takes it
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok = 0;
        if (gap) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = b;
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        check("hs_wait", 32'(ok), 32'd1);
    endtask

    function automatic bit pick_gap(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic pulse_start(input logic [7:0] base, input int n);
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        num_words = 7'(n);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] base, input int n, input logic [7:0] cs,
                           input int gap_mode, input bit poke);
        bit   exp_err;
        bit   got_done = 0;
        int   lat = 0;
        exp_err = (cs != model_csum(n));
        wr_addr.delete();
        wr_data.delete();
        pulse_start(base, n);
        check("err_clr", 32'(err), 32'd0);
        check("busy_start", 32'({busy, cpu_hold}), 32'd3);
        if (poke) begin
            start     = 1'b1;
            base_addr = 8'h40;
            num_words = 7'd5;
            @(negedge clk);
            start     = 1'b0;
        end
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 4; j++)
                send_byte(8'(ld_words[i] >> (8 * (3 - j))), pick_gap(gap_mode));
        send_byte(cs, pick_gap(gap_mode));
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            s_valid = 1'b0;
            if (done) begin
                got_done = 1;
                lat = t;
                break;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("done_lat", 32'(lat), 32'd1);
        check("err", 32'(err), 32'(exp_err));
        @(negedge clk);
        check("wr_cnt", 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check("wr_addr", 32'(wr_addr[i]), 32'(8'((base & 8'hFC) + 8'(4 * i))));
            check("wr_data", wr_data[i], ld_words[i]);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = 8'h00;
        num_words = 7'd0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 32'({s_ready, mem_we, cpu_hold, busy, done, err}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, good checksum
        ld_words[0] = 32'h20080005;
        do_load(8'h10, 1, 8'h2D, 0, 0);

        // Three words with a gap before every byte
        ld_words[0] = 32'hDEADBEEF;
        ld_words[1] = 32'h01234567;
        ld_words[2] = 32'h89ABCDEF;
        do_load(8'h00, 3, model_csum(3), 1, 0);

        // Bad checksum, err sticky until next start
        ld_words[0] = 32'h11223344;
        do_load(8'h30, 1, 8'h00, 0, 0);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);

        // Misaligned base near the top of memory wraps to 0
        ld_words[0] = 32'hCAFEF00D;
        ld_words[1] = 32'h0BADC0DE;
        do_load(8'hFE, 2, model_csum(2), 2, 0);

        // Zero words, with a start pulsed while busy
        do_load(8'h50, 0, 8'h00, 0, 1);

        // Randomized loads
        for (int k = 0; k < 8; k++) begin
            int n;
            logic [7:0] cs;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) ld_words[i] = $urandom;
            cs = model_csum(n);
            if ($urandom_range(0, 3) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
            do_load(8'($urandom), n, cs, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of word 2
        ld_words[0] = 32'hA5A50001;
        wr_addr.delete();
        wr_data.delete();
        pulse_start(8'h20, 3);
        for (int j = 0; j < 4; j++) send_byte(8'(ld_words[0] >> (8 * (3 - j))), 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h66, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 32'({s_ready, mem_we, cpu_hold, busy, done, err}), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_wr_cnt", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) check("mid_rst_wr_addr", 32'(wr_addr[0]), 32'h20);

        // Clean load after reset
        ld_words[0] = 32'h13579BDF;
        ld_words[1] = 32'h2468ACE0;
        do_load(8'h80, 2, model_csum(2), 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the byte-addressed, big-endian instruction memory read by the fetch stage. Accepts a byte stream over a valid/ready handshake, packs every four bytes into a 32-bit word (first byte into bits [31:24]), and issues one word write per packed word to the memory write port. Holds the CPU in stall while loading and verifies a trailing XOR checksum byte. Sits between the host/debug byte link and the instruction memory write port.

## Interface
- ADDR_W, 8, byte-address width (memory is 2^ADDR_W bytes)
- CNT_W, 7, width of the word-count input (ADDR_W-1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE
- base_addr  in  ADDR_W  first byte address; bits [1:0] ignored (forced 0)
- num_words  in  CNT_W  number of words to load, 0 allowed
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_ready  out  1  loader can accept a byte
- mem_we  out  1  word write strobe, one cycle per word
- mem_addr  out  ADDR_W  byte address of word, always word-aligned
- mem_wdata  out  32  packed word, big-endian
- cpu_hold  out  1  stall request to the processor
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on completion (good or bad)
- err  out  1  checksum mismatch; sticky until next accepted start

## Operation
- Clocking: one clock; reset is asynchronous and active-low. On rst_n low, all regs are cleared and the block is in IDLE. Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0.
- States: IDLE, RECV, WRITE, CHECK.
- IDLE: start=1 latches base_addr&~3 into the address reg and num_words into the word counter, clears err, checksum reg and byte index, then goes to RECV (or to CHECK if num_words==0).
- RECV: s_ready=1. Each handshake (s_valid&&s_ready) shifts s_data into the word shift register and XORs it into the checksum reg. The 4th byte goes to WRITE.
- WRITE: s_ready=0, mem_we=1 for exactly one cycle with the current mem_addr/mem_wdata. Then the address advances by 4 (mod 2^ADDR_W) and the counter decrements. If the counter was 1, go to CHECK; otherwise go to RECV.
- CHECK: s_ready=1. The next accepted byte is compared with the checksum reg, and err is set on mismatch. Go to IDLE with done=1.
- start while busy is ignored. s_valid while s_ready=0 is held by the sender (standard valid/ready; no byte is dropped).
- Address wrap: an increment past 2^ADDR_W-4 wraps to 0 silently.
- Reset mid-load: the partial word is discarded, no mem_we is issued, done is not pulsed, and cpu_hold drops immediately.

## Timing
- busy=cpu_hold=1 from the cycle after start is accepted until the cycle done is high (inclusive). Both are 0 in the IDLE cycle following.
- Byte throughput: 1 byte/cycle in RECV. Each word costs 4 accepted bytes plus 1 WRITE cycle.
- Minimum load time for N words: 5N+1 cycles plus 1 cycle for the start.
- done: registered, high exactly one cycle, in the cycle the checksum byte is accepted +1. err is valid in the same cycle as done.
- mem_addr and mem_wdata are stable during the mem_we cycle. Both hold their last value otherwise.

## Structure
- Shared package (imem_pkg): state encoding enum, WORD_BYTES=4, and the byte-lane order constant (big-endian, lane 0 = [31:24]). The instruction memory uses the same package.
- One sub-module is natural: imem_pack_be, a 4-byte shift/pack register with an index counter and a full flag. The FSM, counters and checksum stay in imem_loader.

## Test plan
- Load of 1 word: start, base_addr=0x10, num_words=1, bytes 0x20,0x08,0x00,0x05, checksum 0x2D → single mem_we, mem_addr=0x10, mem_wdata=0x20080005, done pulse, err=0.
- Load of 3 words with s_valid gaps every other cycle → three writes at 0x00/0x04/0x08 with correct data, no byte lost, s_ready=0 during each WRITE cycle.
- Bad checksum: 1 word 0x11223344 with checksum 0x00 (expected 0x44) → word still written, done pulse, err=1, err clears on the next start.
- Wrap and alignment: base_addr=0xFE (forced to 0xFC), num_words=2 → writes at 0xFC then 0x00.
- num_words=0: only the checksum byte 0x00 is sent → no mem_we, done pulse, err=0. A start pulsed during busy is ignored.
- Reset mid-load: assert rst_n=0 after 2 bytes of word 2 → no further mem_we, all outputs return to their reset values asynchronously, and a new load after reset completes normally.
